// File: rtl/multicycle_control_unit_if.sv
// Control-unit bundle: opcode/mem_ready in, datapath controls and status out.
// master = control unit, slave = datapath side.
interface multicycle_control_unit_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             ir_write;
    logic             iord;
    logic             branch;
    logic             memread;
    logic             memtoreg;
    logic             memwrite;
    logic             aluSrc;
    logic             regwrite;
    logic [1:0]       Aluop;
    logic             jump;
    logic             link;
    logic             trap;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] instr_retired;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, ir_write, iord, branch, memread, memtoreg,
               memwrite, aluSrc, regwrite, Aluop, jump, link, trap, state_o, instr_retired
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, ir_write, iord, branch, memread, memtoreg,
               memwrite, aluSrc, regwrite, Aluop, jump, link, trap, state_o, instr_retired
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXECUTE/MEM/WB with memory timeout trap.
// Optional JAL/JALR support is enabled by defining MC_CU_JUMP_EN.
module multicycle_control_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    multicycle_control_unit_if.master  bus
);
    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd7
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int              WAIT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t             state_reg, state_next;
    logic [WAIT_W-1:0]  wait_cnt_reg;
    logic [6:0]         opcode_reg;
    logic [CNT_W-1:0]   retired_reg;
    logic               retire;
    logic               timeout_hit;

    logic pc_write_c, pc_write_cond_c, ir_write_c, iord_c, branch_c, memread_c;
    logic memtoreg_c, memwrite_c, alusrc_c, regwrite_c, jump_c, link_c, trap_c;
    logic [1:0] aluop_c;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_ITYPE: is_legal = 1'b1;
`ifdef MC_CU_JUMP_EN
            OP_JAL, OP_JALR:                                  is_legal = 1'b1;
`endif
            default:                                          is_legal = 1'b0;
        endcase
    endfunction

    // A ready on the last allowed wait cycle still completes the access.
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (wait_cnt_reg == WAIT_LAST) && !bus.mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
            opcode_reg   <= '0;
            retired_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg)
                wait_cnt_reg <= '0;
            else if (state_reg == S_FETCH || state_reg == S_MEM)
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            if (state_reg == S_DECODE)
                opcode_reg <= bus.opcode;
            if (retire)
                retired_reg <= retired_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next      = state_reg;
        retire          = 1'b0;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        ir_write_c      = 1'b0;
        iord_c          = 1'b0;
        branch_c        = 1'b0;
        memread_c       = 1'b0;
        memtoreg_c      = 1'b0;
        memwrite_c      = 1'b0;
        alusrc_c        = 1'b0;
        regwrite_c      = 1'b0;
        aluop_c         = 2'b00;
        jump_c          = 1'b0;
        link_c          = 1'b0;
        trap_c          = 1'b0;

        case (state_reg)
            S_FETCH: begin
                memread_c = 1'b1;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    state_next = S_TRAP;
                end
            end
            S_DECODE: state_next = is_legal(bus.opcode) ? S_EXECUTE : S_TRAP;
            S_EXECUTE: begin
                case (opcode_reg)
                    OP_LOAD, OP_STORE: begin
                        alusrc_c   = 1'b1;
                        state_next = S_MEM;
                    end
                    OP_RTYPE: begin
                        aluop_c    = 2'b10;
                        state_next = S_WB;
                    end
                    OP_ITYPE: begin
                        alusrc_c   = 1'b1;
                        state_next = S_WB;
                    end
                    OP_BRANCH: begin
                        aluop_c         = 2'b01;
                        branch_c        = 1'b1;
                        pc_write_cond_c = 1'b1;
                        retire          = 1'b1;
                        state_next      = S_FETCH;
                    end
`ifdef MC_CU_JUMP_EN
                    OP_JAL, OP_JALR: begin
                        jump_c     = 1'b1;
                        pc_write_c = 1'b1;
                        alusrc_c   = 1'b1;
                        state_next = S_WB;
                    end
`endif
                    default: state_next = S_TRAP;
                endcase
            end
            S_MEM: begin
                iord_c     = 1'b1;
                memread_c  = (opcode_reg == OP_LOAD);
                memwrite_c = (opcode_reg == OP_STORE);
                if (bus.mem_ready) begin
                    state_next = (opcode_reg == OP_LOAD) ? S_WB : S_FETCH;
                    retire     = (opcode_reg != OP_LOAD);
                end else if (timeout_hit) begin
                    state_next = S_TRAP;
                end
            end
            S_WB: begin
                regwrite_c = 1'b1;
                memtoreg_c = (opcode_reg == OP_LOAD);
`ifdef MC_CU_JUMP_EN
                link_c     = (opcode_reg == OP_JAL) || (opcode_reg == OP_JALR);
`endif
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP:  trap_c = 1'b1;
            default: state_next = S_TRAP;
        endcase

        // Reset masks every control so an aborted instruction never writes.
        if (reset) begin
            pc_write_c      = 1'b0;
            pc_write_cond_c = 1'b0;
            ir_write_c      = 1'b0;
            iord_c          = 1'b0;
            branch_c        = 1'b0;
            memread_c       = 1'b0;
            memtoreg_c      = 1'b0;
            memwrite_c      = 1'b0;
            alusrc_c        = 1'b0;
            regwrite_c      = 1'b0;
            aluop_c         = 2'b00;
            jump_c          = 1'b0;
            link_c          = 1'b0;
            trap_c          = 1'b0;
        end
    end

    assign bus.pc_write      = pc_write_c;
    assign bus.pc_write_cond = pc_write_cond_c;
    assign bus.ir_write      = ir_write_c;
    assign bus.iord          = iord_c;
    assign bus.branch        = branch_c;
    assign bus.memread       = memread_c;
    assign bus.memtoreg      = memtoreg_c;
    assign bus.memwrite      = memwrite_c;
    assign bus.aluSrc        = alusrc_c;
    assign bus.regwrite      = regwrite_c;
    assign bus.Aluop         = aluop_c;
    assign bus.jump          = jump_c;
    assign bus.link          = link_c;
    assign bus.trap          = trap_c;
    assign bus.state_o       = state_reg;
    assign bus.instr_retired = retired_reg;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (TIMEOUT_CYCLES=4); JAL path checked when MC_CU_JUMP_EN is defined.
module tb_multicycle_control_unit;
    localparam logic [14:0] PCW  = 15'h1 << 14;
    localparam logic [14:0] PCC  = 15'h1 << 13;
    localparam logic [14:0] IRW  = 15'h1 << 12;
    localparam logic [14:0] IORD = 15'h1 << 11;
    localparam logic [14:0] BR   = 15'h1 << 10;
    localparam logic [14:0] MR   = 15'h1 << 9;
    localparam logic [14:0] M2R  = 15'h1 << 8;
    localparam logic [14:0] MW   = 15'h1 << 7;
    localparam logic [14:0] ASRC = 15'h1 << 6;
    localparam logic [14:0] RW   = 15'h1 << 5;
    localparam logic [14:0] AF   = 15'h1 << 4;
    localparam logic [14:0] ASUB = 15'h1 << 3;
    localparam logic [14:0] JMP  = 15'h1 << 2;
    localparam logic [14:0] LNK  = 15'h1 << 1;
    localparam logic [14:0] TRP  = 15'h1;
    localparam logic [14:0] FRDY = MR | IRW | PCW;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [14:0] ctl;

    multicycle_control_unit_if #(.CNT_W(32)) bus ();

    multicycle_control_unit #(.TIMEOUT_CYCLES(4), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign ctl = {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.iord, bus.branch,
                  bus.memread, bus.memtoreg, bus.memwrite, bus.aluSrc, bus.regwrite,
                  bus.Aluop, bus.jump, bus.link, bus.trap};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the current state/controls, then advance one clock.
    task automatic step(input string tag, input logic [2:0] st, input logic [14:0] c);
        #1;
        check({tag, "_state"}, 32'(bus.state_o), 32'(st));
        check({tag, "_ctl"}, 32'(ctl), 32'(c));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        bus.opcode = 7'd0;
        @(posedge clk); @(posedge clk); #1;
        step("reset", 3'd0, 15'd0);
        check("reset_cnt", bus.instr_retired, 32'd0);
        reset = 1'b0;

        // R-type with memory always ready
        bus.mem_ready = 1'b1; bus.opcode = 7'b0110011;
        step("r_fetch", 3'd0, FRDY);
        step("r_dec", 3'd1, 15'd0);
        bus.opcode = 7'd0;
        step("r_exe", 3'd2, AF);
        step("r_wb", 3'd4, RW);
        check("r_cnt", bus.instr_retired, 32'd1);
        $display("instr rtype state=%0d retired=%0d", bus.state_o, bus.instr_retired);

        // load with three MEM wait cycles (ready on the last allowed cycle)
        bus.opcode = 7'b0000011;
        step("ld_fetch", 3'd0, FRDY);
        step("ld_dec", 3'd1, 15'd0);
        bus.opcode = 7'd0;
        step("ld_exe", 3'd2, ASRC);
        bus.mem_ready = 1'b0;
        step("ld_mem0", 3'd3, IORD | MR);
        step("ld_mem1", 3'd3, IORD | MR);
        step("ld_mem2", 3'd3, IORD | MR);
        bus.mem_ready = 1'b1;
        step("ld_mem3", 3'd3, IORD | MR);
        step("ld_wb", 3'd4, RW | M2R);
        check("ld_cnt", bus.instr_retired, 32'd2);
        $display("instr load state=%0d retired=%0d", bus.state_o, bus.instr_retired);

        // store then branch
        bus.opcode = 7'b0100011;
        step("st_fetch", 3'd0, FRDY);
        step("st_dec", 3'd1, 15'd0);
        step("st_exe", 3'd2, ASRC);
        step("st_mem", 3'd3, IORD | MW);
        check("st_cnt", bus.instr_retired, 32'd3);
        $display("instr store state=%0d retired=%0d", bus.state_o, bus.instr_retired);
        bus.opcode = 7'b1100011;
        step("br_fetch", 3'd0, FRDY);
        step("br_dec", 3'd1, 15'd0);
        step("br_exe", 3'd2, BR | PCC | ASUB);
        check("br_state", 32'(bus.state_o), 32'd0);
        check("br_cnt", bus.instr_retired, 32'd4);
        $display("instr branch state=%0d retired=%0d", bus.state_o, bus.instr_retired);

        // I-type
        bus.opcode = 7'b0010011;
        step("i_fetch", 3'd0, FRDY);
        step("i_dec", 3'd1, 15'd0);
        step("i_exe", 3'd2, ASRC);
        step("i_wb", 3'd4, RW);
        check("i_cnt", bus.instr_retired, 32'd5);
        $display("instr itype state=%0d retired=%0d", bus.state_o, bus.instr_retired);

        // FETCH ready on the 4th (timeout) cycle completes normally
        bus.mem_ready = 1'b0; bus.opcode = 7'b0110011;
        step("to_f0", 3'd0, MR);
        step("to_f1", 3'd0, MR);
        step("to_f2", 3'd0, MR);
        bus.mem_ready = 1'b1;
        step("to_f3", 3'd0, FRDY);
        step("to_dec", 3'd1, 15'd0);
        step("to_exe", 3'd2, AF);
        step("to_wb", 3'd4, RW);
        check("to_cnt", bus.instr_retired, 32'd6);
        $display("instr late_fetch state=%0d retired=%0d", bus.state_o, bus.instr_retired);

        // reset during WB suppresses regwrite and clears the counter
        step("rw_fetch", 3'd0, FRDY);
        step("rw_dec", 3'd1, 15'd0);
        step("rw_exe", 3'd2, AF);
        reset = 1'b1;
        step("rw_wb", 3'd4, 15'd0);
        reset = 1'b0;
        check("rw_state", 32'(bus.state_o), 32'd0);
        check("rw_cnt", bus.instr_retired, 32'd0);
        $display("instr reset_in_wb state=%0d retired=%0d", bus.state_o, bus.instr_retired);

        // illegal opcode traps after DECODE; reset recovers
        bus.opcode = 7'b1111111;
        step("il_fetch", 3'd0, FRDY);
        step("il_dec", 3'd1, 15'd0);
        step("il_trap", 3'd7, TRP);
        reset = 1'b1;
        step("il_rst", 3'd7, 15'd0);
        reset = 1'b0;
        $display("instr illegal state=%0d retired=%0d", bus.state_o, bus.instr_retired);

        // FETCH timeout: TRAP entered on the 4th edge, then held despite mem_ready
        bus.mem_ready = 1'b0; bus.opcode = 7'b0110011;
        step("tt_f0", 3'd0, MR);
        step("tt_f1", 3'd0, MR);
        step("tt_f2", 3'd0, MR);
        step("tt_f3", 3'd0, MR);
        for (int i = 0; i < 20; i++) begin
            bus.mem_ready = i[0];
            step("tt_hold", 3'd7, TRP);
        end
        check("tt_cnt", bus.instr_retired, 32'd0);
        reset = 1'b1;
        step("tt_rst", 3'd7, 15'd0);
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        step("tt_after", 3'd0, MR);
        $display("instr timeout state=%0d retired=%0d", bus.state_o, bus.instr_retired);

        // JAL: jump path when enabled, trap otherwise
        bus.mem_ready = 1'b1; bus.opcode = 7'b1101111;
        step("jal_fetch", 3'd0, FRDY);
        step("jal_dec", 3'd1, 15'd0);
`ifdef MC_CU_JUMP_EN
        step("jal_exe", 3'd2, JMP | PCW | ASRC);
        step("jal_wb", 3'd4, RW | LNK);
        check("jal_cnt", bus.instr_retired, 32'd1);
`else
        step("jal_trap", 3'd7, TRP);
        check("jal_cnt", bus.instr_retired, 32'd0);
`endif
        $display("instr jal state=%0d retired=%0d", bus.state_o, bus.instr_retired);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
